// File: rtl/seq_scan_if.sv
// Control/status bundle for seq_scan: scan controls in, channel index/one-hot/strobes out.
// The mask signal exists only when SEQ_SKIP_MASK_EN is defined.
interface seq_scan_if #(
  parameter int N_CH    = 8,
  parameter int DWELL_W = 16
);
  localparam int TICK_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                en;
  logic                dir;
  logic [DWELL_W-1:0]  dwell;
  logic                sync_clr;
`ifdef SEQ_SKIP_MASK_EN
  logic [N_CH-1:0]     mask;
`endif
  logic [TICK_W-1:0]   tick;
  logic [N_CH-1:0]     sel;
  logic                step;
  logic                wrap;

`ifdef SEQ_SKIP_MASK_EN
  modport master (output en, dir, dwell, sync_clr, mask,
                  input  tick, sel, step, wrap);
  modport slave  (input  en, dir, dwell, sync_clr, mask,
                  output tick, sel, step, wrap);
`else
  modport master (output en, dir, dwell, sync_clr,
                  input  tick, sel, step, wrap);
  modport slave  (input  en, dir, dwell, sync_clr,
                  output tick, sel, step, wrap);
`endif
endinterface

// File: rtl/seq_scan.sv
// One-hot channel scanner with programmable dwell, direction, restart and step/wrap strobes.
// Optional skip mask enabled by defining SEQ_SKIP_MASK_EN.
module seq_scan #(
  parameter int N_CH    = 8,
  parameter int DWELL_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_scan_if.slave  bus
);
  localparam int TICK_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [DWELL_W-1:0] cnt_q,  cnt_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]    sel_q,  sel_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;

  logic [TICK_W-1:0]  nxt_tick;
  logic               nxt_wrap;
  logic               nxt_valid;

  // Candidate k steps away from the current channel; k == N_CH is a full lap back to itself.
  always_comb begin : next_ch
    int cand;
    cand      = 0;
    nxt_tick  = tick_q;
    nxt_wrap  = 1'b0;
    nxt_valid = 1'b0;
`ifdef SEQ_SKIP_MASK_EN
    for (int k = 1; k <= N_CH; k++) begin
      cand = bus.dir ? (int'(tick_q) + N_CH - k) % N_CH
                     : (int'(tick_q) + k) % N_CH;
      if (!nxt_valid && !bus.mask[TICK_W'(cand)]) begin
        nxt_valid = 1'b1;
        nxt_tick  = TICK_W'(cand);
        nxt_wrap  = bus.dir ? (k > int'(tick_q)) : (int'(tick_q) + k >= N_CH);
      end
    end
`else
    cand      = bus.dir ? (int'(tick_q) + N_CH - 1) % N_CH
                        : (int'(tick_q) + 1) % N_CH;
    nxt_valid = 1'b1;
    nxt_tick  = TICK_W'(cand);
    nxt_wrap  = bus.dir ? (tick_q == '0) : (int'(tick_q) == N_CH - 1);
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = tick_q;
    sel_d  = sel_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.sync_clr) begin
      cnt_d  = '0;
      tick_d = '0;
      sel_d  = N_CH'(1);
    end else if (bus.en) begin
      // >= rather than == so shrinking dwell mid-slot advances immediately
      if (cnt_q >= bus.dwell) begin
        cnt_d = '0;
        if (nxt_valid) begin
          tick_d = nxt_tick;
          sel_d  = N_CH'(1) << nxt_tick;
          step_d = 1'b1;
          wrap_d = nxt_wrap;
        end
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= '0;
      sel_q  <= N_CH'(1);
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sel_q  <= sel_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.tick = tick_q;
  assign bus.sel  = sel_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_seq_scan.sv
// Bench for seq_scan: 8- and 5-channel instances against a ring-walking reference model.
// Mask scenarios are exercised when SEQ_SKIP_MASK_EN is defined.
module tb_seq_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_scan_if #(.N_CH(8), .DWELL_W(16)) bus8 ();
  seq_scan_if #(.N_CH(5), .DWELL_W(16)) bus5 ();

  seq_scan #(.N_CH(8), .DWELL_W(16)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  seq_scan #(.N_CH(5), .DWELL_W(16)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

  int errs = 0;
  int checks = 0;

  logic       en_v = 1'b0, dir_v = 1'b0, clr_v = 1'b0;
  int         dwell_v = 0;
  logic [7:0] mask_v = 8'h00;

  int NCH [2] = '{8, 5};
  int m_tick [2];
  int m_cnt  [2];
  bit m_step [2];
  bit m_wrap [2];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, exp, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    bus8.en = en_v;  bus8.dir = dir_v;  bus8.sync_clr = clr_v;  bus8.dwell = 16'(dwell_v);
    bus5.en = en_v;  bus5.dir = dir_v;  bus5.sync_clr = clr_v;  bus5.dwell = 16'(dwell_v);
`ifdef SEQ_SKIP_MASK_EN
    bus8.mask = mask_v;
    bus5.mask = mask_v[4:0];
`endif
  endtask

  task automatic model_reset(input int d);
    m_tick[d] = 0; m_cnt[d] = 0; m_step[d] = 0; m_wrap[d] = 0;
  endtask

  function automatic bit is_masked(input int c);
`ifdef SEQ_SKIP_MASK_EN
    return ((int'(mask_v) >> c) & 1) != 0;
`else
    return (c < 0);
`endif
  endfunction

  // Walks the ring one position at a time until an unmasked channel turns up.
  task automatic model_step(input int d);
    int  c;
    bit  crossed;
    m_step[d] = 0;
    m_wrap[d] = 0;
    if (!rst_n)  begin model_reset(d); return; end
    if (clr_v)   begin m_tick[d] = 0; m_cnt[d] = 0; return; end
    if (!en_v)   return;
    if (m_cnt[d] < dwell_v) begin m_cnt[d]++; return; end
    m_cnt[d] = 0;
    c = m_tick[d];
    crossed = 0;
    for (int k = 0; k < NCH[d]; k++) begin
      if (!dir_v) begin
        if (c == NCH[d] - 1) begin c = 0; crossed = 1; end else c++;
      end else begin
        if (c == 0) begin c = NCH[d] - 1; crossed = 1; end else c--;
      end
      if (!is_masked(c)) begin
        m_tick[d] = c; m_step[d] = 1; m_wrap[d] = crossed;
        return;
      end
    end
  endtask

  task automatic compare_all();
    chk("tick8", int'(bus8.tick), m_tick[0]);
    chk("sel8",  int'(bus8.sel),  1 << m_tick[0]);
    chk("step8", int'(bus8.step), int'(m_step[0]));
    chk("wrap8", int'(bus8.wrap), int'(m_wrap[0]));
    chk("tick5", int'(bus5.tick), m_tick[1]);
    chk("sel5",  int'(bus5.sel),  1 << m_tick[1]);
    chk("step5", int'(bus5.step), int'(m_step[1]));
    chk("wrap5", int'(bus5.wrap), int'(m_wrap[1]));
    chk("range5", int'(bus5.tick < 3'd5), 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_cycle();
    clr_v = 1'b1; apply_inputs();
    cycle();
    clr_v = 1'b0; apply_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset(0);
    model_reset(1);
    apply_inputs();
    repeat (2) @(negedge clk);
    // T1: reset values and ascending walk
    chk("rst_tick", int'(bus8.tick), 0);
    chk("rst_sel",  int'(bus8.sel), 8'h01);
    chk("rst_step", int'(bus8.step), 0);
    compare_all();
    rst_n = 1'b1;
    en_v = 1'b1; dir_v = 1'b0; dwell_v = 0; apply_inputs();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t1_sel",  int'(bus8.sel), 1 << ((i + 1) % 8));
      chk("t1_step", int'(bus8.step), 1);
      chk("t1_wrap", int'(bus8.wrap), (i == 7) ? 1 : 0);
    end

    // T3: descending from channel 0
    dir_v = 1'b1; apply_inputs();
    cycle();
    chk("t3_tick", int'(bus8.tick), 7);
    chk("t3_sel",  int'(bus8.sel), 8'h80);
    chk("t3_wrap", int'(bus8.wrap), 1);
    cycle();
    chk("t3_tick2", int'(bus8.tick), 6);
    chk("t3_wrap2", int'(bus8.wrap), 0);

    // T6: five channels, never beyond index 4
    dir_v = 1'b0; apply_inputs();
    clear_cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t6_tick", int'(bus5.tick), (i + 1) % 5);
      chk("t6_wrap", int'(bus5.wrap), (i == 4) ? 1 : 0);
    end
    dir_v = 1'b1; apply_inputs();
    cycle();
    chk("t6_down", int'(bus5.tick), 4);
    chk("t6_dwrap", int'(bus5.wrap), 1);

    // T2: dwell=3 and freeze with cnt=2
    dir_v = 1'b0; dwell_v = 3; apply_inputs();
    clear_cycle();
    repeat (2) cycle();
    chk("t2_pre", int'(bus8.tick), 0);
    en_v = 1'b0; apply_inputs();
    repeat (5) cycle();
    chk("t2_frz_tick", int'(bus8.tick), 0);
    chk("t2_frz_step", int'(bus8.step), 0);
    en_v = 1'b1; apply_inputs();
    cycle();
    chk("t2_re1_step", int'(bus8.step), 0);
    cycle();
    chk("t2_re2_step", int'(bus8.step), 1);
    chk("t2_re2_tick", int'(bus8.tick), 1);
    repeat (3) cycle();
    chk("t2_hold", int'(bus8.tick), 1);
    cycle();
    chk("t2_next", int'(bus8.tick), 2);

    // T4: sync restart mid-dwell, then async reset mid-cycle
    dwell_v = 0; apply_inputs();
    clear_cycle();
    repeat (5) cycle();
    chk("t4_at5", int'(bus8.tick), 5);
    dwell_v = 3; apply_inputs();
    cycle();
    clear_cycle();
    chk("t4_clr_tick", int'(bus8.tick), 0);
    chk("t4_clr_sel",  int'(bus8.sel), 8'h01);
    chk("t4_clr_step", int'(bus8.step), 0);
    dwell_v = 0; apply_inputs();
    repeat (3) cycle();
    dwell_v = 3; apply_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_arst_tick", int'(bus8.tick), 0);
    chk("t4_arst_sel",  int'(bus8.sel), 8'h01);
    chk("t4_arst_step", int'(bus8.step), 0);
    model_reset(0);
    model_reset(1);
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("t4_lat_hold", int'(bus8.tick), 0);
    cycle();
    chk("t4_lat_adv", int'(bus8.tick), 1);
    chk("t4_lat_step", int'(bus8.step), 1);

`ifdef SEQ_SKIP_MASK_EN
    // T5: skip mask
    dwell_v = 0; apply_inputs();
    clear_cycle();
    mask_v = 8'b0110_0110; apply_inputs();
    cycle(); chk("t5_a", int'(bus8.tick), 3);
    cycle(); chk("t5_b", int'(bus8.tick), 4);
    cycle(); chk("t5_c", int'(bus8.tick), 7);
    cycle(); chk("t5_d", int'(bus8.tick), 0);
    chk("t5_wrap", int'(bus8.wrap), 1);
    mask_v = 8'hFF; apply_inputs();
    repeat (3) cycle();
    chk("t5_all_tick", int'(bus8.tick), 0);
    chk("t5_all_step", int'(bus8.step), 0);
    mask_v = 8'h00; apply_inputs();
`endif

    // Randomised phase
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1'b1;
      en_v  = ($urandom_range(0, 9) != 0);
      dir_v = ($urandom_range(0, 7) == 0) ? ~dir_v : dir_v;
      clr_v = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) dwell_v = $urandom_range(0, 4);
`ifdef SEQ_SKIP_MASK_EN
      if ($urandom_range(0, 19) == 0) begin
        mask_v = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 9) == 0) mask_v = ~(8'h01 << $urandom_range(0, 7));
      end
`endif
      apply_inputs();
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
